// File: rtl/operand_fetch_if.sv
`default_nettype none
// ============================================================================
// Module   : operand_fetch_if
// Purpose  : Bundles the signals around the operand collector: the decode
//            request handshake, the register-file read port, the writeback
//            snoop bus and the execute operand handshake.
// Modports : slave  - operand_fetch side (drives req_ready, rf_*, op_*)
//            master - surrounding pipeline (decode, register file, writeback,
//                     execute)
// Revision : 1.0 - initial release
// ============================================================================
interface operand_fetch_if #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
);
    // decode -> fetch request
    logic            req_valid;
    logic            req_ready;
    logic [RA_W-1:0] req_rs1;
    logic [RA_W-1:0] req_rs2;
    logic            req_use_rs2;
    // single-read-port register file
    logic [RA_W-1:0] rf_ra1;
    logic [RA_W-1:0] rf_ra2;
    logic            rf_rsel;
    logic [XLEN-1:0] rf_rd;
    // writeback bus (same strobe as the register file write)
    logic            wb_we;
    logic [RA_W-1:0] wb_wa;
    logic [XLEN-1:0] wb_wd;
    // fetch -> execute operands
    logic            op_valid;
    logic            op_ready;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;

    modport slave (
        input  req_valid, req_rs1, req_rs2, req_use_rs2,
        input  rf_rd,
        input  wb_we, wb_wa, wb_wd,
        input  op_ready,
        output req_ready, rf_ra1, rf_ra2, rf_rsel,
        output op_valid, op_a, op_b
    );

    modport master (
        output req_valid, req_rs1, req_rs2, req_use_rs2,
        output rf_rd,
        output wb_we, wb_wa, wb_wd,
        output op_ready,
        input  req_ready, rf_ra1, rf_ra2, rf_rsel,
        input  op_valid, op_a, op_b
    );
endinterface
`default_nettype wire

// File: rtl/operand_fetch.sv
`default_nettype none
// ============================================================================
// Module   : operand_fetch
// Purpose  : Sequential operand collector between decode and execute. Reads
//            rs1 then rs2 through a single register-file read port on
//            consecutive cycles and presents both operands under a
//            valid/ready handshake.
// Ports    : clk   - clock, rising edge
//            rst_n - asynchronous active-low reset
//            bus   - operand_fetch_if.slave (request, register file,
//                    writeback snoop, operand handshake)
// Options  : OPFETCH_FWD_EN - when defined, writeback data is forwarded at
//            capture time and snooped into already-captured operands while
//            in RD2/DONE. When undefined the wb_* inputs are ignored.
// Revision : 1.0 - initial release
// ============================================================================
module operand_fetch #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    operand_fetch_if.slave     bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD1  = 2'd1,
        RD2  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state, state_nx;
    logic [RA_W-1:0] rs1, rs1_nx;
    logic [RA_W-1:0] rs2, rs2_nx;
    logic            use_rs2, use_rs2_nx;
    logic [XLEN-1:0] op_a, op_a_nx;
    logic [XLEN-1:0] op_b, op_b_nx;

    logic            hit_rs1;
    logic            hit_rs2;
    logic [XLEN-1:0] cap_rs1;
    logic [XLEN-1:0] cap_rs2;

`ifdef OPFETCH_FWD_EN
    // A write to x0 never hits: x0 is hard-wired to zero.
    assign hit_rs1 = bus.wb_we && (bus.wb_wa == rs1) && (rs1 != '0);
    assign hit_rs2 = bus.wb_we && (bus.wb_wa == rs2) && (rs2 != '0);
`else
    assign hit_rs1 = 1'b0;
    assign hit_rs2 = 1'b0;
    logic unused_wb;
    assign unused_wb = ^{bus.wb_we, bus.wb_wa};
`endif

    // Capture value: x0 reads zero regardless of the register file, and a
    // same-cycle writeback to the register being read wins over the stale
    // register-file data.
    assign cap_rs1 = (rs1 == '0) ? '0 : (hit_rs1 ? bus.wb_wd : bus.rf_rd);
    assign cap_rs2 = (rs2 == '0) ? '0 : (hit_rs2 ? bus.wb_wd : bus.rf_rd);

    // Handshake and read-port outputs are pure decodes of state and latches,
    // so op_valid falls together with an asynchronous reset.
    assign bus.req_ready = (state == IDLE);
    assign bus.op_valid  = (state == DONE);
    assign bus.rf_rsel   = (state == RD2);
    assign bus.rf_ra1    = rs1;
    assign bus.rf_ra2    = rs2;
    assign bus.op_a      = op_a;
    assign bus.op_b      = op_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            rs1     <= '0;
            rs2     <= '0;
            use_rs2 <= 1'b0;
            op_a    <= '0;
            op_b    <= '0;
        end else begin
            state   <= state_nx;
            rs1     <= rs1_nx;
            rs2     <= rs2_nx;
            use_rs2 <= use_rs2_nx;
            op_a    <= op_a_nx;
            op_b    <= op_b_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        rs1_nx     = rs1;
        rs2_nx     = rs2;
        use_rs2_nx = use_rs2;
        op_a_nx    = op_a;
        op_b_nx    = op_b;

        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    rs1_nx     = bus.req_rs1;
                    rs2_nx     = bus.req_rs2;
                    use_rs2_nx = bus.req_use_rs2;
                    state_nx   = RD1;
                end
            end
            RD1: begin
                op_a_nx = cap_rs1;
                if (use_rs2) begin
                    state_nx = RD2;
                end else begin
                    op_b_nx  = '0;
                    state_nx = DONE;
                end
            end
            RD2: begin
                // op_a is already captured, so it is snooped here; when
                // rs1 == rs2 both operands pick up the same wb_wd.
                op_b_nx = cap_rs2;
                if (hit_rs1) begin
                    op_a_nx = bus.wb_wd;
                end
                state_nx = DONE;
            end
            DONE: begin
                if (hit_rs1) begin
                    op_a_nx = bus.wb_wd;
                end
                // A single-operand instruction keeps op_b at zero even if
                // the unused rs2 field happens to match the write.
                if (use_rs2 && hit_rs2) begin
                    op_b_nx = bus.wb_wd;
                end
                if (bus.op_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule
`default_nettype wire
